iterative_divider: RTL

Multi-cycle, parametrised integer divider for the multdiv unit. It is the sequential successor to the combinational 32-bit subtract/compare path. It performs one restoring subtract-compare step per clock, in signed or unsigned mode, and returns quotient, remainder and a divide-by-zero exception with a one-cycle ready pulse. The processor's multdiv wrapper instantiates it beside the multiplier.

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/iterative_divider_if.sv | 25 ++
 rtl/iterative_divider_width_subtractor.sv | 21 ++
 rtl/iterative_divider.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: FSM states, default width and
// the counter-width helper used by the iterative divider.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int MULTDIV_WIDTH = 32;

    // Bits needed to count 0..v-1 (at least 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Handshake / operand / result bundle of the iterative divider.
// master = requester (multdiv wrapper or bench), slave = divider.
interface iterative_divider_if #(
    parameter int WIDTH = multdiv_pkg::MULTDIV_WIDTH
);
    logic             ctrl_DIV;
    logic             is_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, is_signed, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, is_signed, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/iterative_divider_width_subtractor.sv
// Combinational W-bit subtractor a - b. The MSB of the difference is split
// out as the sign: the divider operands are sized so the true difference
// always fits in W signed bits, so neg=1 means "a < b".
module width_subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-2:0] diff,
    output logic         neg
);
    logic [W-1:0] full;

    // Plain two's-complement difference, MSB is the sign.
    always_comb begin
        full = a - b;
    end

    assign diff = full[W-2:0];
    assign neg  = full[W-1];
endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider: one subtract/compare step per clock.
// Latency WIDTH+1 edges from start to the registered result (1 edge for a
// zero divisor). A start pulse in any state aborts and restarts.
// Optional feature macro: IDIV_SIGNED_EN (honours is_signed; without it all
// operations are unsigned and FIX is a pass-through).
module iterative_divider
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULTDIV_WIDTH
) (
    input  logic               clock,
    input  logic               reset_n,
    iterative_divider_if.slave bus
);
    localparam int                CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder (always < divisor)
    logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               negq_q, negq_d;   // negate quotient in FIX
    logic               negr_q, negr_d;   // negate remainder in FIX
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   remout_q, remout_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic               signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     shifted;          // WIDTH+1-bit shifted partial remainder
    logic [WIDTH-1:0]   sub_diff;
    logic               sub_neg;

    // Shift in the next dividend bit; compare against the divisor.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    width_subtractor #(.W(WIDTH + 1)) u_sub (
        .a    (shifted),
        .b    ({1'b0, dvsr_q}),
        .diff (sub_diff),
        .neg  (sub_neg)
    );

`ifdef IDIV_SIGNED_EN
    assign signed_op = bus.is_signed;
`else
    assign signed_op = 1'b0;
`endif

    assign a_neg = signed_op & bus.data_operandA[WIDTH-1];
    assign b_neg = signed_op & bus.data_operandB[WIDTH-1];

    // Next-state and datapath: start has priority over every state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dbz_d    = dbz_q;
        res_d    = res_q;
        remout_d = remout_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (bus.ctrl_DIV) begin
            cnt_d  = '0;
            rem_d  = '0;
            exc_d  = 1'b0;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            dvsr_d = b_neg ? -bus.data_operandB : bus.data_operandB;
            if (bus.data_operandB == '0) begin
                // Keep the raw dividend; it is returned as the remainder.
                dbz_d   = 1'b1;
                quo_d   = bus.data_operandA;
                state_d = FIX;
            end else begin
                dbz_d   = 1'b0;
                quo_d   = a_neg ? -bus.data_operandA : bus.data_operandA;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    rem_d = sub_neg ? shifted[WIDTH-1:0] : sub_diff;
                    quo_d = {quo_q[WIDTH-2:0], ~sub_neg};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    rdy_d   = 1'b1;
                    exc_d   = dbz_q;
                    state_d = IDLE;
                    if (dbz_q) begin
                        res_d    = '0;
                        remout_d = quo_q;
                    end else begin
                        res_d    = negq_q ? -quo_q : quo_q;
                        remout_d = negr_q ? -rem_q : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers, all cleared by the async reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_q    <= '0;
            remout_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dbz_q    <= dbz_d;
            res_q    <= res_d;
            remout_q <= remout_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_remainder = remout_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    // Busy spans RUN/FIX and the RDY cycle itself.
    assign bus.busy           = (state_q != IDLE) || rdy_q;

endmodule
